// File: rtl/reg_bank_mp.sv
// Parametrised multi-read-port register bank with write->read bypass, busy scoreboard
// and a sequential post-reset clear that raises ready once every register is zeroed.
//
// state   | meaning
// S_CLEAR | zeroing one register per clock, all traffic ignored, outputs held at 0
// S_READY | normal operation: reads, writes, issue/writeback scoreboard
module reg_bank_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic                 ready
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     clr_cnt, clr_cnt_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;

  // Address names a real, writable register (excludes the hardwired zero and holes above DEPTH).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    ready       = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == AW'(DEPTH - 1)) state_nxt = S_READY;
      end
      S_READY: ready = 1'b1;
      default: state_nxt = S_CLEAR;
    endcase
  end

  assign wr_ok = ready && wr_en && addr_ok(wr_addr);

  // Storage has no reset; the clear sweep owns it until ready.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) mem[clr_cnt] <= '0;
    else if (wr_ok)       mem[wr_addr] <= wr_data;
  end

  // Issue is applied after writeback so a same-cycle new producer keeps the register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (ready) begin
      if (wr_ok) busy[wr_addr] <= 1'b0;
      if (iss_en && addr_ok(iss_addr)) busy[iss_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          ok;
    logic          hit;

    assign ra  = rd_addr[i*AW +: AW];
    assign ok  = ready && addr_ok(ra);
    assign hit = (BYPASS != 0) && wr_ok && (wr_addr == ra) && ok;

    assign rd_data[i*WIDTH +: WIDTH] = !ok ? '0 : (hit ? wr_data : mem[ra]);
    assign rd_busy[i]                = ok && busy[ra] && !hit;
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Self-checking bench for reg_bank_mp: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model (BYPASS=1 and 0).
module tb_reg_bank_mp;

  localparam int W = 64;
  localparam int D = 32;
  localparam int N = 2;
  localparam int A = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*A-1:0] rd_addr;
  logic           wr_en;
  logic [A-1:0]   wr_addr;
  logic [W-1:0]   wr_data;
  logic           iss_en;
  logic [A-1:0]   iss_addr;

  logic [N*W-1:0] rd_data, rd_data_nb;
  logic [N-1:0]   rd_busy, rd_busy_nb;
  logic           ready, ready_nb;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: register contents, outstanding producers, clear cycles remaining.
  logic [W-1:0] m_mem [D];
  bit   [D-1:0] m_busy = '0;
  int           m_left = D;

  always #5 clk = ~clk;

  reg_bank_mp #(.WIDTH(W), .DEPTH(D), .NRD(N), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .ready(ready)
  );

  reg_bank_mp #(.WIDTH(W), .DEPTH(D), .NRD(N), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .ready(ready_nb)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [A-1:0] port_addr(input int p);
    return rd_addr[p*A +: A];
  endfunction

  task automatic set_rd(input int p, input logic [A-1:0] a);
    rd_addr[p*A +: A] = a;
  endtask

  // Expected outputs straight from the read rules, for either bypass setting.
  task automatic cmp_all();
    bit on;
    on = rst_n && (m_left == 0);
    chk("ready", W'(ready), W'(on));
    chk("ready_nb", W'(ready_nb), W'(on));
    for (int p = 0; p < N; p++) begin
      logic [A-1:0] a;
      logic [W-1:0] e_d, e_dn;
      bit real_reg, fwd;
      a        = port_addr(p);
      real_reg = on && (a != 0);
      fwd      = real_reg && wr_en && (wr_addr == a);
      e_dn     = real_reg ? m_mem[a] : '0;
      e_d      = fwd ? wr_data : e_dn;
      chk($sformatf("rd_data%0d", p), rd_data[p*W +: W], e_d);
      chk($sformatf("rd_data_nb%0d", p), rd_data_nb[p*W +: W], e_dn);
      chk($sformatf("rd_busy%0d", p), W'(rd_busy[p]), W'(real_reg && m_busy[a] && !fwd));
      chk($sformatf("rd_busy_nb%0d", p), W'(rd_busy_nb[p]), W'(real_reg && m_busy[a]));
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_left = D;
      m_busy = '0;
    end else if (m_left > 0) begin
      m_mem[D - m_left] = '0;
      m_left--;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  // One clock: compare mid-cycle, advance model at the edge, then release to the driver.
  task automatic tick();
    @(negedge clk);
    cmp_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  function automatic logic [A-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return A'($urandom_range(0, D - 1));
    return A'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;

    // Reset for two edges, then the clear sweep: ready rises exactly D edges later.
    tick(); tick();
    rst_n = 1'b1;
    set_rd(0, 5'd4); set_rd(1, 5'd9);
    #2;
    chk("lit_ready_at_release", W'(ready), 64'd0);
    for (int i = 1; i <= D; i++) begin
      tick();
      #2;
      chk($sformatf("lit_ready_edge%0d", i), W'(ready), W'(i == D));
    end
    chk("lit_read_after_clear", rd_data[63:0], 64'd0);

    // Write r2, read it back next cycle; r1 reads 0.
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h1234_5678_9ABC_DEF0;
    tick();
    idle(); set_rd(0, 5'd2); set_rd(1, 5'd1);
    #2;
    chk("lit_r2", rd_data[63:0], 64'h1234_5678_9ABC_DEF0);
    chk("lit_r1", rd_data[127:64], 64'd0);

    // Same-cycle write and read of r7.
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hDEAD_BEEF; set_rd(0, 5'd7);
    #2;
    chk("lit_bypass_r7", rd_data[63:0], 64'hDEAD_BEEF);
    chk("lit_nobypass_r7", rd_data_nb[63:0], 64'd0);

    // Register 0: writes dropped, never busy.
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = '1; iss_en = 1'b1; iss_addr = 5'd0; set_rd(0, 5'd0);
    #2;
    chk("lit_r0_data_wr", rd_data[63:0], 64'd0);
    tick();
    idle();
    #2;
    chk("lit_r0_data", rd_data[63:0], 64'd0);
    chk("lit_r0_busy", W'(rd_busy[0]), 64'd0);

    // Scoreboard on r5.
    iss_en = 1'b1; iss_addr = 5'd5;
    tick();
    idle(); set_rd(0, 5'd5);
    #2;
    chk("lit_r5_busy", W'(rd_busy[0]), 64'd1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h55;
    #2;
    chk("lit_r5_bypass_busy", W'(rd_busy[0]), 64'd0);
    chk("lit_r5_bypass_data", rd_data[63:0], 64'h55);
    chk("lit_r5_nb_busy", W'(rd_busy_nb[0]), 64'd1);
    tick();
    idle();
    #2;
    chk("lit_r5_cleared", W'(rd_busy[0]), 64'd0);
    chk("lit_r5_data", rd_data[63:0], 64'h55);
    iss_en = 1'b1; wr_en = 1'b1; iss_addr = 5'd5; wr_addr = 5'd5; wr_data = 64'h66;
    tick();
    idle();
    #2;
    chk("lit_r5_iss_wins", W'(rd_busy[0]), 64'd1);

    // Mid-run reset aborts everything.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hA5;
    tick();
    wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    idle(); set_rd(0, 5'd3); set_rd(1, 5'd9);
    #2;
    chk("lit_r3_before", rd_data[63:0], 64'hA5);
    chk("lit_r9_busy_before", W'(rd_busy[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("lit_ready_in_reset", W'(ready), 64'd0);
    chk("lit_busy_in_reset", W'(rd_busy), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < D; i++) tick();
    #2;
    chk("lit_ready_again", W'(ready), 64'd1);
    chk("lit_r3_after", rd_data[63:0], 64'd0);
    chk("lit_r9_busy_after", W'(rd_busy[1]), 64'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n    = ($urandom_range(0, 399) != 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = rnd_addr();
      wr_data  = {$urandom, $urandom};
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = rnd_addr();
      for (int p = 0; p < N; p++)
        set_rd(p, ($urandom_range(0, 2) == 0) ? wr_addr : rnd_addr());
    end
    rst_n = 1'b1;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
